// File: rtl/mod_n_checker_pkg.sv
// Shared types and parameter checks for the streaming mod-N divisibility checker.
package mod_chk_pkg;

  // Frame tracking states: nothing seen yet, frame open, frame closed and frozen.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // True when the modulus and beat width fall inside the supported range.
  function automatic logic params_ok(input int mod, input int din_w);
    return (mod >= 2) && (mod <= 255) && (din_w >= 1) && (din_w <= 32);
  endfunction

endpackage

// File: rtl/mod_n_checker_if.sv
// Beat input and result output bundle of the mod-N checker.
interface mod_n_checker_if #(
  parameter int MOD   = 3,
  parameter int DIN_W = 1,
  parameter int CNT_W = 16
);
  localparam int RW = $clog2(MOD);

  logic             din_vld;
  logic [DIN_W-1:0] din;
  logic             sof;
  logic             eof;
  logic [RW-1:0]    rem_o;
  logic             flag_y;
  logic             res_vld;
  logic [RW-1:0]    res_rem;
  logic             res_flag;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output din_vld, din, sof, eof,
    input  rem_o, flag_y, res_vld, res_rem, res_flag, beat_cnt
  );

  modport slave (
    input  din_vld, din, sof, eof,
    output rem_o, flag_y, res_vld, res_rem, res_flag, beat_cnt
  );
endinterface

// File: rtl/mod_n_checker_step.sv
// Combinational residue update: folds one DIN_W-bit beat, MSB first, into a
// running remainder. Each bit doubles the remainder, adds the bit and does at
// most one conditional subtract, so RW+1 bits always hold the intermediate.
module mod_n_step #(
  parameter int MOD   = 3,
  parameter int DIN_W = 1
) (
  input  logic [$clog2(MOD)-1:0] r_in,
  input  logic [DIN_W-1:0]       din,
  output logic [$clog2(MOD)-1:0] r_out
);
  localparam int RW = $clog2(MOD);
  localparam logic [RW:0] MOD_V = MOD[RW:0];

  logic [RW:0] acc_s;

  // Chain of shift-in-bit / conditional-subtract stages, one per din bit.
  always_comb begin
    acc_s = {1'b0, r_in};
    for (int i = DIN_W - 1; i >= 0; i--) begin
      acc_s = {acc_s[RW-1:0], din[i]};
      if (acc_s >= MOD_V) begin
        acc_s = acc_s - MOD_V;
      end else begin
        acc_s = acc_s;
      end
    end
    r_out = acc_s[RW-1:0];
  end
endmodule

// File: rtl/mod_n_checker.sv
// Streaming divisibility checker: running remainder of an MSB-first number,
// framed by sof/eof with a one-cycle per-frame result pulse.
module mod_n_checker
  import mod_chk_pkg::*;
#(
  parameter int MOD   = 3,
  parameter int DIN_W = 1,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mod_n_checker_if.slave bus
);
  localparam int RW = $clog2(MOD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [RW-1:0]    REM_ZERO = {RW{1'b0}};

  if (!params_ok(MOD, DIN_W)) begin : g_param_chk
    $error("mod_n_checker: MOD must be 2..255 and DIN_W 1..32");
  end

  state_e           state_r, state_nxt_s;
  logic [RW-1:0]    rem_r, rem_nxt_s;
  logic [RW-1:0]    step_in_s, step_out_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             flag_r, flag_nxt_s;
  logic             res_vld_r, res_vld_nxt_s;
  logic [RW-1:0]    res_rem_r, res_rem_nxt_s;
  logic             res_flag_r, res_flag_nxt_s;
  logic             start_s;

  // A beat starts a fresh frame on sof, or whenever no frame is open.
  assign start_s   = bus.din_vld && (bus.sof || (state_r != ST_ACC));
  assign step_in_s = start_s ? REM_ZERO : rem_r;

  mod_n_step #(.MOD(MOD), .DIN_W(DIN_W)) u_step (
    .r_in  (step_in_s),
    .din   (bus.din),
    .r_out (step_out_s)
  );

  // Next state, remainder, beat count and frame result for the current beat.
  always_comb begin
    state_nxt_s    = state_r;
    rem_nxt_s      = rem_r;
    cnt_nxt_s      = cnt_r;
    res_vld_nxt_s  = 1'b0;
    res_rem_nxt_s  = res_rem_r;
    res_flag_nxt_s = res_flag_r;
    if (bus.din_vld) begin
      rem_nxt_s = step_out_s;
      if (start_s) begin
        cnt_nxt_s = CNT_ONE;
      end else if (cnt_r != CNT_MAX) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
      if (bus.eof) begin
        state_nxt_s    = ST_HOLD;
        res_vld_nxt_s  = 1'b1;
        res_rem_nxt_s  = step_out_s;
        res_flag_nxt_s = (step_out_s == REM_ZERO);
      end else begin
        state_nxt_s = ST_ACC;
      end
    end else begin
      state_nxt_s = state_r;
    end
    flag_nxt_s = (rem_nxt_s == REM_ZERO) && (state_nxt_s != ST_IDLE);
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output registers: running residue, counter and latched frame result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r      <= REM_ZERO;
      cnt_r      <= {CNT_W{1'b0}};
      flag_r     <= 1'b0;
      res_vld_r  <= 1'b0;
      res_rem_r  <= REM_ZERO;
      res_flag_r <= 1'b0;
    end else begin
      rem_r      <= rem_nxt_s;
      cnt_r      <= cnt_nxt_s;
      flag_r     <= flag_nxt_s;
      res_vld_r  <= res_vld_nxt_s;
      res_rem_r  <= res_rem_nxt_s;
      res_flag_r <= res_flag_nxt_s;
    end
  end

  assign bus.rem_o    = rem_r;
  assign bus.flag_y   = flag_r;
  assign bus.beat_cnt = cnt_r;
  assign bus.res_vld  = res_vld_r;
  assign bus.res_rem  = res_rem_r;
  assign bus.res_flag = res_flag_r;
endmodule

// File: doc/mod_n_checker.md
# mod_n_checker

Parametrised streaming divisibility checker: accumulates an MSB-first number arriving DIN_W bits per beat and continuously reports its remainder modulo MOD and a divisible flag. It generalises the fixed serial mod-3 checker with arbitrary modulus, multi-bit beats, valid qualification, and framing with a per-frame result pulse. It sits on serial/packet datapaths wherever a running residue check is needed, such as checksum pre-screening or test-pattern validation.

## Interface
- MOD, 3, modulus; legal range 2..255
- DIN_W, 1, bits consumed per accepted beat; legal range 1..32
- CNT_W, 16, width of the per-frame beat counter
- RW (localparam), $clog2(MOD), remainder width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- din_vld  in  1  beat qualifier; din/sof/eof are ignored when low
- din  in  DIN_W  data beat, MSB of beat = most significant bits of the number
- sof  in  1  first beat of a frame (qualified by din_vld)
- eof  in  1  last beat of a frame (qualified by din_vld)
- rem_o  out  RW  running remainder of the accumulated value mod MOD
- flag_y  out  1  accumulated value ≡ 0 mod MOD, and at least one beat received
- res_vld  out  1  one-cycle pulse: frame result valid
- res_rem  out  RW  frame remainder, valid with res_vld
- res_flag  out  1  frame divisible, valid with res_vld
- beat_cnt  out  CNT_W  accepted beats in current/last frame, saturating

## Operation
- States: IDLE (after reset, nothing received), ACC (frame open), HOLD (frame closed, outputs frozen).
- Step function: for each din bit, MSB first: r = 2r + b; if r ≥ MOD then r -= MOD. Intermediate width RW+1. The result equals (rem·2^DIN_W + din) mod MOD.
- Accepted beat = din_vld high on a rising edge.
- Start beat: an accepted beat with sof, or any accepted beat in IDLE/HOLD. rem <= step(0, din); beat_cnt <= 1; go to ACC.
- Continue beat: an accepted beat in ACC without sof. rem <= step(rem, din); beat_cnt increments and saturates at 2^CNT_W−1.
- sof in ACC aborts the open frame silently (no res_vld) and restarts it.
- An accepted beat with eof is processed as above, then the state goes to HOLD and res_vld pulses. sof+eof on the same beat forms a single-beat frame.
- HOLD: rem_o, flag_y and beat_cnt hold the frame value until the next accepted beat.
- flag_y = (rem == 0) && state != IDLE.
- eof or sof with din_vld low: no effect.

## Timing
- Reset values: rem_o=0, flag_y=0, res_vld=0, res_rem=0, res_flag=0, beat_cnt=0, state=IDLE.
- rem_o, flag_y and beat_cnt are registered. They reflect beat k in the cycle after the edge that sampled it (1-cycle latency).
- res_vld, res_rem and res_flag are registered in the same edge as the eof beat's remainder. They pulse for exactly one cycle. res_rem/res_flag hold until the next res_vld.
- Back-to-back frames (eof beat followed immediately by a sof beat) are supported at full rate with no bubble.
- Reset mid-frame: all outputs return to reset values asynchronously. The frame is discarded and no res_vld is produced.
- Throughput: one beat per cycle. The combinational step is a chain of DIN_W conditional subtracts.

## Structure
- Package mod_chk_pkg holds:
  - state enum (IDLE/ACC/HOLD)
  - MOD/DIN_W range-check function used in an elaboration-time assertion
- Sub-module mod_n_step is purely combinational: inputs r_in, din; output r_out.
  - Parametrised by MOD and DIN_W.
  - Reused by the top and by the bench's reference model.
- The top holds the state register, remainder register, counter and result registers.

## Test plan
- MOD=3, DIN_W=1: beats 1,1,0,1,1,0,1,0 → flag_y = 0,1,1,0,1,1,0,0 (values 1,3,6,13,27,54,109,218). rem_o ends at 2.
- MOD=7, DIN_W=4: sof 0x1, eof 0xC (28) → res_vld one cycle, res_rem=0, res_flag=1, beat_cnt=2. State is HOLD, and flag_y stays 1 while idle.
- MOD=5, DIN_W=8: single beat with sof+eof, din=0xFF → res_flag=1. Next cycle a sof+eof beat 0x07 → res_rem=2, res_flag=0, with no bubble.
- din_vld gaps: MOD=3, DIN_W=1 stream 1,(gap×3),1 → rem_o/flag_y unchanged during the gaps; flag_y=1 after the second bit.
- Mid-frame sof: frame 1,0 then sof 1,1 eof → no res_vld for the first frame; res_rem=0 (value 3), beat_cnt=2.
- rst_n low mid-frame → all outputs 0 immediately. After release, the first beat starts a new frame, and an eof without a prior sof still yields a correct result.
